// File: rtl/boot_mem.sv
// Parametrised boot memory: INIT-loaded protected low region plus writable scratch words.
// Optional patching of the protected region is enabled by defining BOOTMEM_PATCH_EN.
module boot_mem #(
  parameter int DW = 16,
  parameter int AW = 4,
  parameter int ROM_WORDS = 8,
  parameter logic [DW*ROM_WORDS-1:0] INIT =
    128'h0000_4000_3008_F400_1007_F800_4000_F200
) (
  input  logic          romclk,
  input  logic          rst,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic          lock,
  output logic [DW-1:0] dout,
  output logic          rvalid,
  output logic          wr_err,
  output logic [7:0]    err_cnt,
  output logic          locked
);

  localparam int DEPTH = 1 << AW;
  localparam logic [DW*DEPTH-1:0] IMG = (DW*DEPTH)'(INIT);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] dout_q, dout_d;
  logic          rvalid_q, rvalid_d;
  logic          wr_err_q, wr_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic rom_hit;
  logic rd_req;
  logic wr_req;
  logic wr_ok;

`ifdef BOOTMEM_PATCH_EN
  logic locked_q, locked_d;

  always_comb begin
    locked_d = locked_q | lock;
  end

  always_ff @(posedge romclk or posedge rst) begin
    if (rst) locked_q <= 1'b0;
    else     locked_q <= locked_d;
  end

  assign locked = locked_q;
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign locked      = 1'b1;
`endif

  assign rom_hit = 32'(addr) < 32'(ROM_WORDS);
  assign rd_req  = cs & ~we;
  assign wr_req  = cs & we;
  // Writes use the lock state from before this edge
  assign wr_ok   = ~rom_hit | ~locked;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) mem_d[k] = mem_q[k];
    dout_d    = dout_q;
    rvalid_d  = 1'b0;
    wr_err_d  = 1'b0;
    err_cnt_d = err_cnt_q;
    if (rd_req) begin
      dout_d   = mem_q[addr];
      rvalid_d = 1'b1;
    end
    if (wr_req) begin
      if (wr_ok) begin
        mem_d[addr] = din;
      end else begin
        wr_err_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge romclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= IMG[k*DW +: DW];
      dout_q    <= '0;
      rvalid_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= mem_d[k];
      dout_q    <= dout_d;
      rvalid_q  <= rvalid_d;
      wr_err_q  <= wr_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign dout    = dout_q;
  assign rvalid  = rvalid_q;
  assign wr_err  = wr_err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_boot_mem.sv
// Self-checking bench for boot_mem: vector table applied through a scoreboard queue.
// Build with BOOTMEM_PATCH_EN defined to exercise the patch/lock path.
module tb_boot_mem;

  logic        romclk = 1'b0;
  logic        rst;
  logic        cs, we, lock;
  logic [3:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        rvalid, wr_err, locked;
  logic [7:0]  err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        cs;
    logic        we;
    logic        lock;
    logic [3:0]  addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        rvalid;
    logic        wr_err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  boot_mem dut (
    .romclk (romclk),
    .rst    (rst),
    .cs     (cs),
    .we     (we),
    .addr   (addr),
    .din    (din),
    .lock   (lock),
    .dout   (dout),
    .rvalid (rvalid),
    .wr_err (wr_err),
    .err_cnt(err_cnt),
    .locked (locked)
  );

  always #5 romclk = ~romclk;

  function automatic vec_t mk(logic c, logic w, logic l,
                              logic [3:0] a, logic [15:0] d,
                              logic [15:0] ed, logic ev,
                              logic ee, logic [7:0] ec);
    vec_t v;
    v.cs = c; v.we = w; v.lock = l; v.addr = a; v.din = d;
    v.dout = ed; v.rvalid = ev; v.wr_err = ee; v.cnt = ec;
    return v;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    @(negedge romclk);
    cs = v.cs; we = v.we; lock = v.lock; addr = v.addr; din = v.din;
    sb.push_back(v);
    @(posedge romclk);
    #1;
    e = sb.pop_front();
    chk($sformatf("dout a=%h", e.addr), dout, e.dout);
    chk($sformatf("rvalid a=%h", e.addr), 16'(rvalid), 16'(e.rvalid));
    chk($sformatf("wr_err a=%h", e.addr), 16'(wr_err), 16'(e.wr_err));
    chk($sformatf("err_cnt a=%h", e.addr), 16'(err_cnt), 16'(e.cnt));
    cs = 1'b0; we = 1'b0; lock = 1'b0;
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge romclk);
    rst = 1'b1;
    @(negedge romclk);
    rst = 1'b0;
  endtask

  logic [15:0] rom_img [8];
  logic [7:0]  exp_cnt;
  logic        exp_locked;

  initial begin
    rom_img[0] = 16'hF200; rom_img[1] = 16'h4000;
    rom_img[2] = 16'hF800; rom_img[3] = 16'h1007;
    rom_img[4] = 16'hF400; rom_img[5] = 16'h3008;
    rom_img[6] = 16'h4000; rom_img[7] = 16'h0000;
`ifdef BOOTMEM_PATCH_EN
    exp_locked = 1'b0;
`else
    exp_locked = 1'b1;
`endif
    cs = 0; we = 0; lock = 0; addr = 0; din = 0;
    rst = 1'b1;
    #12;
    chk("reset dout", dout, 16'h0);
    chk("reset rvalid", 16'(rvalid), 16'h0);
    chk("reset wr_err", 16'(wr_err), 16'h0);
    chk("reset err_cnt", 16'(err_cnt), 16'h0);
    chk("reset locked", 16'(locked), 16'(exp_locked));
    @(negedge romclk);
    rst = 1'b0;

    for (int a = 0; a < 8; a++)
      tbl.push_back(mk(1, 0, 0, 4'(a), 0, rom_img[a], 1, 0, 0));
    for (int a = 8; a < 16; a++)
      tbl.push_back(mk(1, 0, 0, 4'(a), 0, 16'h0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'h9, 16'hA5A5, 16'h0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h9, 0, 16'hA5A5, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'h0, 0, 16'hA5A5, 0, 0, 0));
    run_tbl();

`ifdef BOOTMEM_PATCH_EN
    // Lock sampled high with the write: write still lands
    tbl.push_back(mk(1, 1, 1, 4'h2, 16'hBEEF, 16'hA5A5, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h2, 0, 16'hBEEF, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'h2, 16'h0000, 16'hBEEF, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 4'h2, 0, 16'hBEEF, 1, 0, 1));
    run_tbl();
    chk("locked after lock", 16'(locked), 16'h1);
    do_reset();
    chk("locked after rst", 16'(locked), 16'h0);
    tbl.push_back(mk(1, 0, 0, 4'h2, 0, 16'hF800, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'h5, 16'h1111, 16'hF800, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h5, 0, 16'h1111, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h0, 0, 16'h1111, 0, 0, 0));
    run_tbl();
    chk("locked sticky", 16'(locked), 16'h1);
    exp_cnt = 8'd0;
`else
    tbl.push_back(mk(1, 1, 1, 4'h3, 16'h1234, 16'hA5A5, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 4'h3, 0, 16'h1007, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 4'h7, 16'hFFFF, 16'h1007, 0, 1, 2));
    tbl.push_back(mk(1, 0, 0, 4'h7, 0, 16'h0000, 1, 0, 2));
    run_tbl();
    chk("locked const", 16'(locked), 16'h1);
    exp_cnt = 8'd2;
`endif

    for (int i = 0; i < 300; i++) begin
      exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
      apply(mk(1, 1, 0, 4'h0, 16'(i), dout, 0, 1, exp_cnt));
    end
    chk("err_cnt saturated", 16'(err_cnt), 16'h00FF);
    apply(mk(1, 0, 0, 4'h0, 0, 16'hF200, 1, 0, 8'hFF));

    // Asynchronous reset in the middle of a scratch write
    apply(mk(1, 0, 0, 4'h1, 0, 16'h4000, 1, 0, 8'hFF));
    @(negedge romclk);
    cs = 1; we = 1; addr = 4'hC; din = 16'h5555;
    #2;
    rst = 1'b1;
    #1;
    chk("async rst dout", dout, 16'h0);
    chk("async rst rvalid", 16'(rvalid), 16'h0);
    chk("async rst err_cnt", 16'(err_cnt), 16'h0);
    @(posedge romclk);
    @(negedge romclk);
    cs = 0; we = 0;
    rst = 1'b0;
    chk("post rst locked", 16'(locked), 16'(exp_locked));
    apply(mk(1, 0, 0, 4'hC, 0, 16'h0000, 1, 0, 0));
    apply(mk(1, 0, 0, 4'h0, 0, 16'hF200, 1, 0, 0));

    chk("scoreboard drained", 16'(sb.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/boot_mem.md
# boot_mem

Parametrised boot memory for the SoC. It returns a fixed boot image from a protected low region and provides writable scratch words in the high region. The read port is registered with a valid strobe, and illegal writes are counted and reported. It sits on the CPU instruction/data bus at the boot address window and replaces the latch-based, fixed-size 16x16 boot store.

## Interface
Parameters:
- DW, 16: data word width in bits.
- AW, 4: address width; depth is 2^AW words.
- ROM_WORDS, 8: number of protected words at addresses 0..ROM_WORDS-1. Must satisfy 1 <= ROM_WORDS <= 2^AW.
- INIT, 128'h0000_4000_3008_F400_1007_F800_4000_F200: boot image, DW*ROM_WORDS bits. Word k is INIT[k*DW +: DW].

Ports:
- romclk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cs  in  1  chip select.
- we  in  1  write enable; qualified by cs.
- addr  in  AW  word address.
- din  in  DW  write data.
- lock  in  1  patch lock request; used only when BOOTMEM_PATCH_EN is defined.
- dout  out  DW  registered read data.
- rvalid  out  1  one-cycle strobe marking new dout.
- wr_err  out  1  one-cycle strobe for a rejected write.
- err_cnt  out  8  saturating count of rejected writes.
- locked  out  1  patch lock state; tied 1 when the macro is absent.

## Operation
- Storage: 2^AW words of DW bits, held in flops, single port, at most one access per cycle.
- Reset values:
  - ROM words are loaded from INIT.
  - Words ROM_WORDS..2^AW-1 are cleared to 0.
  - dout=0, rvalid=0, wr_err=0, err_cnt=0.
  - locked=0 with BOOTMEM_PATCH_EN, 1 without it.
- Read (cs=1, we=0) at edge N:
  - dout <= mem[addr] and rvalid=1 during cycle N+1.
  - Memory is unchanged.
- Write (cs=1, we=1) at edge N:
  - addr >= ROM_WORDS: mem[addr] <= din. dout is unchanged; rvalid=0 and wr_err=0 in cycle N+1.
  - addr < ROM_WORDS and locked=1: write is dropped, wr_err=1 in cycle N+1, err_cnt increments.
  - addr < ROM_WORDS and locked=0 (macro builds only): mem[addr] <= din.
- Idle (cs=0): dout holds its last read value; rvalid=0, wr_err=0.
- err_cnt saturates at 8'hFF and does not wrap. Only rst clears it.
- Lock: locked rises to 1 on the first edge at which lock=1. It is sticky until rst. A write in the same cycle that lock is first sampled high is evaluated against the old locked value.
- Arithmetic: address compare is unsigned over AW bits. All 2^AW addresses are valid; there is no out-of-range state.

## Timing
- Read latency is 1 cycle (edge N request, data valid after edge N, seen as cycle N+1).
- Back-to-back reads give one rvalid per request with no bubbles.
- Write followed by a read of the same address on the next edge returns the new data.
- Reset during an access aborts the access: no memory update occurs. All outputs take their reset values asynchronously, and the first access after rst falls is honoured normally.

## Configuration
- BOOTMEM_PATCH_EN defined:
  - ROM region is writable until locked is set.
  - Reset reloads INIT, discarding any patches.
  - lock input is live.
- BOOTMEM_PATCH_EN undefined:
  - ROM region is permanently read-only.
  - lock input is ignored and locked is constant 1.
  - No lock flop is built.

## Test plan
- Reset, then read addr 0..7 on consecutive cycles -> dout F200, 4000, F800, 1007, F400, 3008, 4000, 0000, each with rvalid=1 one cycle after its request.
- Read addr 8..F after reset -> dout 0000 each. Then write A5A5 to addr 9 and read 9 on the next edge -> dout A5A5, rvalid=1.
- Without macro, write 1234 to addr 3 -> wr_err=1 for one cycle and err_cnt=1. Read 3 -> 1007.
- Issue 300 rejected writes to addr 0 -> err_cnt stops at FF and wr_err pulses every time.
- With macro:
  - Write BEEF to addr 2, read 2 -> BEEF.
  - Pulse lock, then write 0000 to addr 2 -> wr_err=1, and a read of addr 2 returns BEEF.
  - Assert rst -> addr 2 reads F800, locked=0.
- Assert rst asynchronously mid-cycle during a write of 5555 to addr C -> dout=0 and rvalid=0 immediately, and addr C reads 0000 after release.
